// File: rtl/frame_ingress_arbiter.sv
// Frame-granular round-robin arbiter: shares one AXI-Stream egress among NUM_PORTS sources,
// holding each grant from first beat to tlast, with a programmable inter-frame gap.
module frame_ingress_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [7:0]                      writedata,
    input  logic                            write,
    input  logic                            chipselect,
    input  logic [7:0]                      address,
    input  logic                            read,
    output logic [7:0]                      readdata,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] src_tdata,
    input  logic [NUM_PORTS-1:0]            src_tvalid,
    input  logic [NUM_PORTS-1:0]            src_tlast,
    output logic [NUM_PORTS-1:0]            src_tready,
    output logic [DATA_WIDTH-1:0]           egress_port_tdata,
    output logic                            egress_port_tvalid,
    input  logic                            egress_port_tready,
    output logic                            egress_port_tlast
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]           state;
    logic [PW-1:0]        grant;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        sel;
    logic                 sel_found;
    logic [PW-1:0]        next_ptr;
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] port_enable;
    logic [7:0]           gap_cycles;
    logic [7:0]           gap_cnt;
    logic [7:0]           last_grant;
    logic [7:0]           frame_count;
    logic                 frame_done;

    // Round-robin search: first requesting port at or above rr_ptr, wrapping.
    always_comb begin : arb_search
        int idx;
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        req       = src_tvalid & port_enable;
        sel       = '0;
        sel_found = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!sel_found && req[idx]) begin
                sel       = PW'(idx);
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        egress_port_tdata  = '0;
        egress_port_tvalid = 1'b0;
        egress_port_tlast  = 1'b0;
        src_tready         = '0;
        if (state == ST_GRANT) begin
            egress_port_tdata  = src_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
            egress_port_tvalid = src_tvalid[grant];
            egress_port_tlast  = src_tlast[grant];
            src_tready[grant]  = egress_port_tready;
        end
    end

    assign frame_done = egress_port_tvalid && egress_port_tready && egress_port_tlast;
    assign next_ptr   = (int'(grant) == NUM_PORTS - 1) ? '0 : grant + PW'(1);

    // The gap counter is loaded on GAP entry, so later gap_cycles writes never disturb it.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset) begin
            state       <= ST_IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            gap_cnt     <= 8'h00;
            last_grant  <= 8'h00;
            frame_count <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_found) begin
                        grant      <= sel;
                        last_grant <= 8'(sel);
                        state      <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (frame_done) begin
                        frame_count <= frame_count + 8'd1;
                        rr_ptr      <= next_ptr;
                        gap_cnt     <= gap_cycles;
                        state       <= (gap_cycles != 8'h00) ? ST_GAP : ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt <= 8'd1) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            gap_cycles  <= 8'h00;
            port_enable <= '1;
        end else if (chipselect && write) begin
            case (address)
                8'h00:   gap_cycles  <= writedata;
                8'h01:   port_enable <= writedata[NUM_PORTS-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            readdata <= 8'h00;
        end else if (chipselect && read) begin
            case (address)
                8'h00:   readdata <= gap_cycles;
                8'h01:   readdata <= 8'(port_enable);
                8'h02:   readdata <= last_grant;
                8'h03:   readdata <= frame_count;
                8'h04:   readdata <= {6'b0, state};
                default: readdata <= 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_ingress_arbiter.sv
// Scoreboard bench for frame_ingress_arbiter: directed frames and register accesses push
// expected beats/read data into queues; negedge monitors pop and compare.
module tb_frame_ingress_arbiter;

    localparam int NP = 4;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        writedata;
    logic              write;
    logic              chipselect;
    logic [7:0]        address;
    logic              read;
    logic [7:0]        readdata;
    logic [NP*DW-1:0]  src_tdata;
    logic [NP-1:0]     src_tvalid;
    logic [NP-1:0]     src_tlast;
    logic [NP-1:0]     src_tready;
    logic [DW-1:0]     egress_port_tdata;
    logic              egress_port_tvalid;
    logic              egress_ready;
    logic              egress_port_tlast;

    frame_ingress_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
        .clk                (clk),
        .reset              (reset),
        .writedata          (writedata),
        .write              (write),
        .chipselect         (chipselect),
        .address            (address),
        .read               (read),
        .readdata           (readdata),
        .src_tdata          (src_tdata),
        .src_tvalid         (src_tvalid),
        .src_tlast          (src_tlast),
        .src_tready         (src_tready),
        .egress_port_tdata  (egress_port_tdata),
        .egress_port_tvalid (egress_port_tvalid),
        .egress_port_tready (egress_ready),
        .egress_port_tlast  (egress_port_tlast)
    );

    always #5 clk = ~clk;

    logic [16:0] src_q [NP][$];
    logic [16:0] exp_beats [$];
    logic [7:0]  exp_rd [$];
    int          beat_cyc [$];
    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          beat_cnt = 0;
    logic [NP-1:0] hs     = '0;
    logic        rd_pend  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: read responses, egress beats, and source handshakes for the driver.
    always @(negedge clk) begin
        logic [16:0] e;
        cyc++;
        if (rd_pend) begin
            if (exp_rd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %0h expected nothing", readdata);
            end else begin
                e = {9'b0, exp_rd.pop_front()};
                check("readdata", {24'b0, readdata}, {15'b0, e});
            end
        end
        rd_pend = chipselect && read;
        if (egress_port_tvalid && egress_ready) begin
            beat_cyc.push_back(cyc);
            beat_cnt++;
            if (exp_beats.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected: got %0h expected nothing",
                         {egress_port_tlast, egress_port_tdata});
            end else begin
                e = exp_beats.pop_front();
                check("beat", {15'b0, egress_port_tlast, egress_port_tdata}, {15'b0, e});
            end
        end
        hs = src_tvalid & src_tready;
    end

    // Source driver: advances each port's queue after a handshake.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NP; i++) begin
            if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
                src_tvalid[i]           = 1'b1;
                src_tlast[i]            = src_q[i][0][16];
                src_tdata[i*DW +: DW]   = src_q[i][0][15:0];
            end else begin
                src_tvalid[i]           = 1'b0;
                src_tlast[i]            = 1'b0;
                src_tdata[i*DW +: DW]   = '0;
            end
        end
        hs = '0;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        tick(1);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] e);
        chipselect = 1'b1; read = 1'b1; address = a;
        exp_rd.push_back(e);
        tick(1);
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic send(input int p, input logic [15:0] base, input int n, input bit expect_it);
        logic [16:0] b;
        for (int k = 0; k < n; k++) begin
            b = {(k == n - 1), base + 16'(k)};
            src_q[p].push_back(b);
            if (expect_it) exp_beats.push_back(b);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_beats.size() != 0 && n < 300) begin
            tick(1);
            n++;
        end
        check(name, exp_beats.size(), 0);
    endtask

    task automatic wait_beats(input string name, input int target);
        int n;
        n = 0;
        while (beat_cnt < target && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, 32'(beat_cnt >= target), 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        reset = 1'b0; writedata = '0; write = 1'b0; chipselect = 1'b0;
        address = '0; read = 1'b0; egress_ready = 1'b1;
        src_tdata = '0; src_tvalid = '0; src_tlast = '0;

        // 1: reset state and register defaults
        do_reset();
        check("t1_src_tready", {28'b0, src_tready}, 0);
        check("t1_egress_tvalid", {31'b0, egress_port_tvalid}, 0);
        rd(8'h00, 8'h00);
        rd(8'h01, 8'h0F);
        rd(8'h02, 8'h00);
        rd(8'h03, 8'h00);
        rd(8'h04, 8'h00);

        // 2: ports 0 and 2, 3-beat frames, no gap
        beat_cyc.delete();
        send(0, 16'h0100, 3, 1);
        send(2, 16'h2200, 3, 1);
        wait_drain("t2_drain");
        check("t2_p0_contiguous", beat_cyc[2] - beat_cyc[0], 2);
        check("t2_idle_between", beat_cyc[3] - beat_cyc[2], 2);
        tick(2);
        rd(8'h02, 8'h02);
        rd(8'h03, 8'h02);

        // 3: gap of 5 between back-to-back frames from port 1
        wr(8'h00, 8'h05);
        rd(8'h00, 8'h05);
        beat_cyc.delete();
        send(1, 16'h3100, 2, 1);
        send(1, 16'h3110, 2, 1);
        wait_drain("t3_drain");
        check("t3_beats_contiguous", beat_cyc[1] - beat_cyc[0], 1);
        check("t3_gap_spacing", beat_cyc[2] - beat_cyc[1], 7);
        tick(8);
        rd(8'h04, 8'h00);
        rd(8'h03, 8'h04);

        // 4: all ports requesting single-beat frames after reset
        do_reset();
        rd(8'h03, 8'h00);
        beat_cyc.delete();
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < NP; p++) begin
                send(p, 16'h4000 | 16'(p << 8) | 16'(r), 1, 1);
            end
        end
        wait_drain("t4_drain");
        check("t4_frame_spacing", beat_cyc[4] - beat_cyc[3], 2);
        tick(2);
        rd(8'h02, 8'h03);
        rd(8'h03, 8'h08);

        // 5: disable port 1 while its frame is in flight
        b0 = beat_cnt;
        send(1, 16'h5100, 4, 1);
        wait_beats("t5_wait_first", b0 + 1);
        wr(8'h01, 8'h0D);
        send(1, 16'h5200, 2, 0);
        send(3, 16'h5300, 1, 1);
        send(0, 16'h5000, 1, 1);
        wait_drain("t5_drain");
        tick(6);
        check("t5_port1_not_ready", {28'b0, src_tready}, 0);
        rd(8'h04, 8'h00);
        rd(8'h01, 8'h0D);
        rd(8'h02, 8'h00);
        rd(8'h03, 8'h0B);
        src_q[1].delete();
        tick(2);
        wr(8'h01, 8'h0F);

        // 6a: reset on beat 2 of a 4-beat frame
        b0 = beat_cnt;
        send(0, 16'h6000, 4, 0);
        exp_beats.push_back({1'b0, 16'h6000});
        exp_beats.push_back({1'b0, 16'h6001});
        wait_beats("t6a_wait_first", b0 + 1);
        tick(1);
        reset = 1'b0;
        tick(1);
        src_q[0].delete();
        @(negedge clk);
        #1;
        check("t6a_tvalid_drop", {31'b0, egress_port_tvalid}, 0);
        check("t6a_tready_drop", {28'b0, src_tready}, 0);
        tick(1);
        reset = 1'b1;
        rd(8'h04, 8'h00);
        rd(8'h03, 8'h00);
        check("t6a_truncated", exp_beats.size(), 0);

        // 6b: stall egress for 3 cycles on beat 2 while port 3 also requests
        b0 = beat_cnt;
        send(0, 16'h6100, 4, 1);
        wait_beats("t6b_wait_first", b0 + 1);
        tick(1);
        send(3, 16'h6300, 1, 1);
        egress_ready = 1'b0;
        chipselect = 1'b1; read = 1'b1; address = 8'h04;
        exp_rd.push_back(8'h01);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("t6b_stall_data", {16'b0, egress_port_tdata}, 32'h6101);
            check("t6b_stall_tvalid", {31'b0, egress_port_tvalid}, 1);
            check("t6b_stall_tready", {28'b0, src_tready}, 0);
            tick(1);
            if (k == 0) begin
                chipselect = 1'b0; read = 1'b0;
            end
        end
        egress_ready = 1'b1;
        wait_drain("t6b_drain");
        tick(2);
        rd(8'h02, 8'h03);
        rd(8'h03, 8'h02);

        tick(3);
        check("final_beat_queue", exp_beats.size(), 0);
        check("final_read_queue", exp_rd.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
